// File: rtl/keypad_decoder_if.sv
// rtl/keypad_decoder_if.sv - keypad scanner input and key-code stream bundle
//
// Purpose: groups the scanner sample inputs and the key-code output stream of
// keypad_decoder into one bundle.
// Signals:
//   key_down   scanner sees any row active
//   key_row    one-hot row, bit3 = row 0
//   key_col    one-hot column, bit3 = column 0
//   out_code   FIFO head key code (0 when empty)
//   out_valid  FIFO non-empty
//   out_ready  consumer accept
//   fifo_count FIFO occupancy 0..4
//   overflow   sticky, a code was dropped
// Modports: master = scanner/consumer side, slave = decoder side.
interface keypad_decoder_if;
   logic       key_down;
   logic [3:0] key_row;
   logic [3:0] key_col;
   logic [3:0] out_code;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] fifo_count;
   logic       overflow;

   modport master (
      output key_down, key_row, key_col, out_ready,
      input  out_code, out_valid, fifo_count, overflow
   );

   modport slave (
      input  key_down, key_row, key_col, out_ready,
      output out_code, out_valid, fifo_count, overflow
   );
endinterface

// File: rtl/keypad_decoder.sv
// rtl/keypad_decoder.sv - debounced 4x4 keypad decoder with 4-entry code FIFO
//
// Purpose: debounces one-hot row/column samples from a keypad scanner, turns
// each accepted press into a 4-bit code (row*4 + col) and queues it in a
// 4-deep FIFO read through a valid/ready stream.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   kp     keypad_decoder_if.slave (key inputs, code stream, count, overflow)
// Parameters:
//   DEBOUNCE_CYCLES  stable samples to accept a press or a release (2..255)
//   REPEAT_CYCLES    auto-repeat period in cycles (2..65535)
// Optional feature: define KEYPAD_REPEAT_EN to enable auto-repeat while held.
module keypad_decoder #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned REPEAT_CYCLES   = 200
) (
   input logic             clk,
   input logic             rst_n,
   keypad_decoder_if.slave kp
);

   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES out of range 2..255");
   end
   if (REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_bad_repeat
      $error("REPEAT_CYCLES out of range 2..65535");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_CAND,
      S_PRESSED,
      S_RELEASE
   } state_t;

   // The first stable sample is taken in IDLE with the counter at 0, so the
   // DEBOUNCE_CYCLES-th sample is seen while the counter holds DEBOUNCE_CYCLES-2.
   localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 2);

   // ------------------------------------------------------------------
   // Sample decode
   // ------------------------------------------------------------------
   logic       sample_valid;
   logic [3:0] sample_code;
   logic [1:0] row_idx;
   logic [1:0] col_idx;

   always_comb begin
      row_idx = 2'd0;
      col_idx = 2'd0;
      // bit3 is index 0, so index = 3 - bit position
      for (int i = 0; i < 4; i++) begin
         if (kp.key_row[i]) row_idx = 2'(3 - i);
         if (kp.key_col[i]) col_idx = 2'(3 - i);
      end
   end

   assign sample_valid = kp.key_down && ($countones(kp.key_row) == 1)
                                     && ($countones(kp.key_col) == 1);
   assign sample_code  = {row_idx, col_idx};

   // ------------------------------------------------------------------
   // Debounce FSM
   // ------------------------------------------------------------------
   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] code_q, code_d;
   logic       push;
`ifdef KEYPAD_REPEAT_EN
   localparam logic [15:0] REP_LAST = 16'(REPEAT_CYCLES - 1);
   logic [15:0] rep_q, rep_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         code_q  <= 4'd0;
`ifdef KEYPAD_REPEAT_EN
         rep_q   <= 16'd0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
`ifdef KEYPAD_REPEAT_EN
         rep_q   <= rep_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      push    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_d   = rep_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (sample_valid) begin
               code_d  = sample_code;
               cnt_d   = 8'd0;
               state_d = S_CAND;
            end
         end
         S_CAND: begin
            if (!sample_valid) begin
               cnt_d   = 8'd0;
               state_d = S_IDLE;
            end else if (sample_code != code_q) begin
               code_d = sample_code;
               cnt_d  = 8'd0;
            end else if (cnt_q == CNT_LAST) begin
               push    = 1'b1;
               cnt_d   = 8'd0;
               state_d = S_PRESSED;
`ifdef KEYPAD_REPEAT_EN
               rep_d   = 16'd0;
`endif
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_PRESSED: begin
            if (!sample_valid) begin
               cnt_d   = 8'd0;
               state_d = S_RELEASE;
`ifdef KEYPAD_REPEAT_EN
               rep_d   = 16'd0;
`endif
            end
`ifdef KEYPAD_REPEAT_EN
            // Only an unbroken hold of the accepted code advances the period.
            else if (sample_code == code_q) begin
               if (rep_q == REP_LAST) begin
                  push  = 1'b1;
                  rep_d = 16'd0;
               end else begin
                  rep_d = rep_q + 16'd1;
               end
            end else begin
               rep_d = 16'd0;
            end
`endif
         end
         S_RELEASE: begin
            if (sample_valid) begin
               cnt_d   = 8'd0;
               state_d = S_PRESSED;
`ifdef KEYPAD_REPEAT_EN
               rep_d   = 16'd0;
`endif
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = 8'd0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // 4 x 4-bit FIFO
   // ------------------------------------------------------------------
   logic [3:0] mem_q [4];
   logic [1:0] wr_ptr_q, rd_ptr_q;
   logic [2:0] count_q;
   logic       ovf_q;
   logic       pop;
   logic       full;
   logic       wr_en;

   assign pop   = (count_q != 3'd0) && kp.out_ready;
   assign full  = (count_q == 3'd4);
   // A pop on the same edge frees the slot the push needs.
   assign wr_en = push && (!full || pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         count_q  <= 3'd0;
         ovf_q    <= 1'b0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 2'd1;
         if (pop)   rd_ptr_q <= rd_ptr_q + 2'd1;
         case ({wr_en, pop})
            2'b10:   count_q <= count_q + 3'd1;
            2'b01:   count_q <= count_q - 3'd1;
            default: count_q <= count_q;
         endcase
         if (push && full && !pop) ovf_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= code_q;
   end

   assign kp.out_valid  = (count_q != 3'd0);
   assign kp.out_code   = (count_q != 3'd0) ? mem_q[rd_ptr_q] : 4'd0;
   assign kp.fifo_count = count_q;
   assign kp.overflow   = ovf_q;

endmodule
